fifo_ptr_ctrl: RTL

Parametrised pointer/flag controller for one side of a dual-clock FIFO. It is the successor to the plain enable-gated gray counter.
- Owns the local binary/gray pointer.
- Synchronises the remote gray pointer into the local clock.
- Generates a registered full (write side) or empty (read side) flag, a fill level, an almost-threshold flag and a sticky overflow/underflow error.
- Two instances, one per clock domain, plus a dual-port RAM form a complete async FIFO.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/bin2gray.sv | 11 +
 rtl/gray2bin.sv | 17 +
 rtl/fifo_ptr_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO pointer controllers: side selection
// constants, the full-compare pattern and a gray-to-binary helper.
package fifo_pkg;

   localparam bit FIFO_SIDE_WR = 1'b1;
   localparam bit FIFO_SIDE_RD = 1'b0;

   // Full pattern: the remote gray pointer with its top two bits inverted.
   // For a 2-bit pointer (depth 2) this inverts both bits, which is exactly
   // the "top two bits alone" case. Pointer width must be 2..32.
   function automatic logic [31:0] full_pattern(input logic [31:0] gray,
                                                input int unsigned ptr_w);
      return gray ^ (32'd3 << (ptr_w - 2));
   endfunction

   // Gray to binary, zero-extended operands: bit i is the XOR of all bits >= i.
   function automatic logic [31:0] gray_to_bin(input logic [31:0] gray);
      logic [31:0] b;
      b = '0;
      for (int i = 0; i < 32; i++) begin
         b[i] = ^(gray >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/bin2gray.sv
// Binary to reflected gray code conversion (combinational).
module bin2gray #(
   parameter int DATA_WIDTH = 4
) (
   input  logic [DATA_WIDTH-1:0] bin_i,
   output logic [DATA_WIDTH-1:0] gray_o
);

   assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray2bin.sv
// Gray to binary conversion as a combinational XOR prefix from the MSB down.
module gray2bin #(
   parameter int DATA_WIDTH = 4
) (
   input  logic [DATA_WIDTH-1:0] gray_i,
   output logic [DATA_WIDTH-1:0] bin_o
);

   // Each binary bit is the parity of the gray bits at and above it.
   always_comb begin
      bin_o = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         bin_o[i] = ^(gray_i >> i);
      end
   end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Pointer/flag controller for one side of a dual-clock FIFO. Owns the local
// binary/gray pointer, synchronises the remote gray pointer and produces
// registered full/empty, fill level, almost flag and a sticky error.
//
// Handshake: inc_i is a request that is taken on a rising clk_i edge only when
// flag_o is low (accepted = inc_i & ~flag_o). A request seen while flag_o is
// high is dropped, leaves the pointer unchanged and sets err_o until reset.
module fifo_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH  = 5,
   parameter bit IS_WR       = FIFO_SIDE_WR,
   parameter int SYNC_STAGES = 2,   // legal range 2..4
   parameter int THRESH      = 4
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  inc_i,
   input  logic [ADDR_WIDTH:0]   ptr_gray_remote_i,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic [ADDR_WIDTH:0]   ptr_gray_o,
   output logic                  flag_o,
   output logic                  almost_o,
   output logic [ADDR_WIDTH:0]   level_o,
   output logic                  err_o
);

   localparam int unsigned PW    = ADDR_WIDTH + 1;
   localparam int          DEPTH = 1 << ADDR_WIDTH;
   localparam logic [PW-1:0] ALMOST_FULL_LVL  = PW'(DEPTH - THRESH);
   localparam logic [PW-1:0] ALMOST_EMPTY_LVL = PW'(THRESH);
   localparam bit FLAG_RST = (IS_WR == FIFO_SIDE_RD);

   logic [PW-1:0] r_bin;
   logic [PW-1:0] r_gray;
   logic [PW-1:0] r_level;
   logic          r_flag;
   logic          r_almost;
   logic          r_err;

   logic          w_acc;
   logic [PW-1:0] w_bin_next;
   logic [PW-1:0] w_gray_next;
   logic [PW-1:0] w_rgray_s;
   logic [PW-1:0] w_rbin_s;
   logic [PW-1:0] w_level_next;
   logic          w_flag_next;
   logic          w_almost_next;

   assign w_acc      = inc_i & ~r_flag;
   assign w_bin_next = r_bin + PW'(w_acc);

   bin2gray #(.DATA_WIDTH(PW)) u_bin2gray (
      .bin_i  (w_bin_next),
      .gray_o (w_gray_next)
   );

   // Remote pointer synchroniser: a chain of SYNC_STAGES flops.
   for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
      logic [PW-1:0] r_stage;
      if (s == 0) begin : g_first
         // First stage samples the asynchronous remote pointer.
         always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) r_stage <= '0;
            else         r_stage <= ptr_gray_remote_i;
         end
      end else begin : g_next
         // Later stages resolve metastability of the previous stage.
         always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) r_stage <= '0;
            else         r_stage <= g_sync[s-1].r_stage;
         end
      end
   end

   assign w_rgray_s = g_sync[SYNC_STAGES-1].r_stage;

   gray2bin #(.DATA_WIDTH(PW)) u_gray2bin (
      .gray_i (w_rgray_s),
      .bin_o  (w_rbin_s)
   );

   // Next flag, level and almost, all derived from the post-update pointer so
   // the flag asserts on the very edge that fills or empties the FIFO.
   always_comb begin
      w_flag_next   = 1'b0;
      w_level_next  = '0;
      w_almost_next = 1'b0;
      if (IS_WR == FIFO_SIDE_WR) begin
         w_flag_next   = (32'(w_gray_next) == full_pattern(32'(w_rgray_s), PW));
         w_level_next  = w_bin_next - w_rbin_s;
         w_almost_next = (w_level_next >= ALMOST_FULL_LVL);
      end else begin
         w_flag_next   = (w_gray_next == w_rgray_s);
         w_level_next  = w_rbin_s - w_bin_next;
         w_almost_next = (w_level_next <= ALMOST_EMPTY_LVL);
      end
   end

   // Pointer, flags, level and sticky error registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_bin    <= '0;
         r_gray   <= '0;
         r_level  <= '0;
         r_flag   <= FLAG_RST;
         r_almost <= FLAG_RST;
         r_err    <= 1'b0;
      end else begin
         r_bin    <= w_bin_next;
         r_gray   <= w_gray_next;
         r_level  <= w_level_next;
         r_flag   <= w_flag_next;
         r_almost <= w_almost_next;
         r_err    <= r_err | (inc_i & r_flag);
      end
   end

   assign addr_o     = r_bin[ADDR_WIDTH-1:0];
   assign ptr_gray_o = r_gray;
   assign flag_o     = r_flag;
   assign almost_o   = r_almost;
   assign level_o    = r_level;
   assign err_o      = r_err;

endmodule
